serial_tx_shifter: RTL and testbench
====================================

// Module: serial_tx_shifter
// PURPOSE
//   Parallel-in, serial-out frame transmitter. Drives one serial data line that a
//   flip-flop based serial receiver samples on posedge clk.
//   Accepts a WIDTH-bit word via a valid/ready handshake and emits a frame:
//     start bit (0), data LSB-first, optional even parity, stop bit (1).
//   Line idles high. Back-to-back frames run without idle gaps.
// PARAMETERS
//   WIDTH      8   data bits per frame (>= 2)
//   PARITY_EN  1   1: insert even-parity bit after data; 0: no parity bit
// PORTS
//   clk         in   1      single clock; all state updates on posedge
//   reset       in   1      synchronous, active-high reset
//   load_valid  in   1      load_data is valid this cycle
//   load_ready  out  1      transmitter can accept a word this cycle
//   load_data   in   WIDTH  word to transmit; sampled on accept
//   sdata       out  1      serial line, registered
//   sframe      out  1      high during start, data and parity bits, registered
//   busy        out  1      high from the cycle after accept until the stop bit completes
//   done        out  1      one-cycle pulse coincident with the stop bit
// BEHAVIOUR
//   Reset (reset=1 at posedge): state=IDLE, sdata=1, sframe=0, busy=0, done=0,
//     shift register and bit counter cleared.
//     load_ready=0 in any cycle where reset=1.
//   Accept: load_valid & load_ready at posedge N. The shift register loads load_data
//     and parity = ^load_data.
//   load_ready = ~reset & (state==IDLE | state==STOP). It is combinational from state.
//   FSM (one bit per cycle; outputs below hold for the cycle spent in that state):
//     IDLE   sdata=1 sframe=0 busy=0 done=0. Accept -> START.
//     START  sdata=0 sframe=1 busy=1. -> DATA.
//     DATA   sdata=shreg[0] sframe=1 busy=1. shreg shifts right each cycle.
//            Stays WIDTH cycles (counter 0..WIDTH-1).
//            Then -> PARITY if PARITY_EN, else -> STOP.
//     PARITY sdata=even parity (XOR of the sampled word) sframe=1 busy=1. -> STOP.
//     STOP   sdata=1 sframe=0 busy=1 done=1. Accept -> START, else -> IDLE.
//   Latency: accept at edge N gives the start bit at N+1 and data bit i at N+2+i.
//     Parity (if enabled) at N+2+WIDTH. Stop at N+2+WIDTH+PARITY_EN.
//   Frame length: WIDTH+2+PARITY_EN cycles. Throughput is one frame per frame length
//     when load_valid is held high.
//   load_valid while busy and not in STOP: ignored, load_ready=0, and the word is not
//     captured. The source must hold the word until accepted.
//   load_data changes after accept have no effect on the frame in flight.
//   Reset mid-frame: the frame is aborted. Next cycle shows idle outputs (sdata=1, busy=0).
//     done does not pulse for the aborted frame.
//   Counter width: $clog2(WIDTH). No wrap beyond WIDTH-1; it clears on entering DATA.
// TESTING
//   1 Reset held 3 cycles -> sdata=1, sframe=0, busy=0, done=0, load_ready=0.
//     load_ready=1 on the first cycle after reset is released.
//   2 WIDTH=8, PARITY_EN=1: load 8'hA5 -> sdata sequence 0,1,0,1,0,0,1,0,1,0,1
//     (start, data, parity=0, stop). done high only on the 11th cycle.
//   3 Load 8'h01 -> parity bit = 1. Hold load_valid with 8'h80 next: accepted in STOP.
//     START follows the stop bit with no idle cycle. Second parity = 1.
//   4 Pulse load_valid with 8'h3C during DATA -> not accepted. The frame in flight is
//     unchanged and busy stays continuous.
//   5 Assert reset during DATA bit 3 -> next cycle sdata=1, busy=0, sframe=0.
//     No done pulse. A new load of 8'h0F then transmits correctly.
//   6 PARITY_EN=0: load 8'hC3 -> 10-cycle frame 0,1,1,0,0,0,0,1,1,1. done on cycle 10.

Source files
------------

// File: rtl/serial_tx_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_shifter_if
//  Purpose  : Load handshake and serial-line bundle for serial_tx_shifter.
//             master = word source / line observer, slave = transmitter.
//  Signals  : load_valid, load_ready, load_data[WIDTH-1:0]  word handshake
//             sdata, sframe, busy, done                     serial side
//  Revision : 1.0  initial release
// ============================================================================
interface serial_tx_shifter_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             sdata;
  logic             sframe;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, sdata, sframe, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, sdata, sframe, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_shifter
//  Purpose  : Parallel-in, serial-out frame transmitter. Frame is
//             start(0), data LSB-first, optional even parity, stop(1).
//             Line idles high; back-to-back frames have no idle gap.
//  Ports    : clk    in   clock, all state updates on posedge
//             reset  in   synchronous active-high reset
//             bus    slave modport: load_valid/load_ready/load_data handshake,
//                    sdata/sframe/busy/done registered line outputs
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_shifter #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  serial_tx_shifter_if.slave bus
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [WIDTH-1:0]   r_shreg;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_par;
  logic               r_sdata;
  logic               r_sframe;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic               w_sdata_d;
  logic               w_sframe_d;
  logic               w_busy_d;
  logic               w_done_d;

  assign bus.load_ready = ~reset & ((r_state == c_st_idle) | (r_state == c_st_stop));
  assign w_accept       = bus.load_valid & bus.load_ready;

  // State register, datapath and registered line outputs. The outputs are
  // registered from the next-state decode so they describe the state the
  // FSM is in for the whole of the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_par    <= 1'b0;
      r_sdata  <= 1'b1;
      r_sframe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sdata  <= w_sdata_d;
      r_sframe <= w_sframe_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;

      if (w_accept) begin
        r_shreg <= bus.load_data;
        r_par   <= ^bus.load_data;
      end else if (w_state_nxt == c_st_data) begin
        // bit 0 goes onto the line at this edge, so drop it from the register
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end

      if (r_state != c_st_data) begin
        r_cnt <= '0;
      end else if (r_cnt != c_cnt_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_accept) w_state_nxt = c_st_start;
      c_st_start:  w_state_nxt = c_st_data;
      c_st_data:   if (r_cnt == c_cnt_last)
                     w_state_nxt = PARITY_EN ? c_st_parity : c_st_stop;
      c_st_parity: w_state_nxt = c_st_stop;
      c_st_stop:   w_state_nxt = w_accept ? c_st_start : c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode of the state being entered
  always_comb begin
    w_sdata_d  = 1'b1;
    w_sframe_d = 1'b0;
    w_busy_d   = 1'b1;
    w_done_d   = 1'b0;
    case (w_state_nxt)
      c_st_start: begin
        w_sdata_d  = 1'b0;
        w_sframe_d = 1'b1;
      end
      c_st_data: begin
        w_sdata_d  = r_shreg[0];
        w_sframe_d = 1'b1;
      end
      c_st_parity: begin
        w_sdata_d  = r_par;
        w_sframe_d = 1'b1;
      end
      c_st_stop: begin
        w_done_d = 1'b1;
      end
      default: begin
        w_busy_d = 1'b0;
      end
    endcase
  end

  assign bus.sdata  = r_sdata;
  assign bus.sframe = r_sframe;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_shifter
//  Purpose  : Directed self-checking bench for serial_tx_shifter. One DUT
//             with parity (WIDTH=8) and one without, sharing clk and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx_shifter;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  serial_tx_shifter_if #(.WIDTH(8)) b_par ();
  serial_tx_shifter_if #(.WIDTH(8)) b_np  ();

  serial_tx_shifter #(.WIDTH(8), .PARITY_EN(1'b1)) u_dut_par (
    .clk   (clk),
    .reset (reset),
    .bus   (b_par.slave)
  );

  serial_tx_shifter #(.WIDTH(8), .PARITY_EN(1'b0)) u_dut_np (
    .clk   (clk),
    .reset (reset),
    .bus   (b_np.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one frame starting in its START cycle. seq holds the expected line
  // in reading order (first bit at seq[len-1]). If pulse_k >= 0, load_valid
  // is pulsed with 8'h3C during cycle pulse_k of the parity DUT's frame.
  task automatic frame_chk(input string tag, input logic [15:0] seq, input int len,
                           input bit np, input int pulse_k);
    logic sd, sf, bz, dn, rdy;
    for (int k = 0; k < len; k++) begin
      if (pulse_k >= 0) begin
        if (k == pulse_k) begin
          b_par.load_valid = 1'b1;
          b_par.load_data  = 8'h3C;
        end else begin
          b_par.load_valid = 1'b0;
        end
      end
      sd  = np ? b_np.sdata      : b_par.sdata;
      sf  = np ? b_np.sframe     : b_par.sframe;
      bz  = np ? b_np.busy       : b_par.busy;
      dn  = np ? b_np.done       : b_par.done;
      rdy = np ? b_np.load_ready : b_par.load_ready;
      chk($sformatf("%s_sdata[%0d]", tag, k), 32'(sd), 32'(seq[len-1-k]));
      chk($sformatf("%s_sframe[%0d]", tag, k), 32'(sf), 32'(k != len - 1));
      chk($sformatf("%s_busy[%0d]", tag, k), 32'(bz), 32'd1);
      chk($sformatf("%s_done[%0d]", tag, k), 32'(dn), 32'(k == len - 1));
      chk($sformatf("%s_ready[%0d]", tag, k), 32'(rdy), 32'(k == len - 1));
      step();
    end
    if (pulse_k >= 0) b_par.load_valid = 1'b0;
  endtask

  initial begin
    n_total          = 0;
    n_bad            = 0;
    reset            = 1'b1;
    b_par.load_valid = 1'b0;
    b_par.load_data  = '0;
    b_np.load_valid  = 1'b0;
    b_np.load_data   = '0;

    // 1: reset held for three cycles
    repeat (3) step();
    chk("rst_sdata",  32'(b_par.sdata),      32'd1);
    chk("rst_sframe", 32'(b_par.sframe),     32'd0);
    chk("rst_busy",   32'(b_par.busy),       32'd0);
    chk("rst_done",   32'(b_par.done),       32'd0);
    chk("rst_ready",  32'(b_par.load_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready",  32'(b_par.load_ready), 32'd1);

    // 2: 8'hA5 with parity
    b_par.load_valid = 1'b1;
    b_par.load_data  = 8'hA5;
    step();
    b_par.load_valid = 1'b0;
    frame_chk("a5", 16'(11'b01010010101), 11, 1'b0, -1);
    chk("a5_idle_sdata", 32'(b_par.sdata), 32'd1);
    chk("a5_idle_busy",  32'(b_par.busy),  32'd0);
    chk("a5_idle_done",  32'(b_par.done),  32'd0);

    // 3: 8'h01 then 8'h80 held valid, accepted in STOP with no gap
    b_par.load_valid = 1'b1;
    b_par.load_data  = 8'h01;
    step();
    b_par.load_data  = 8'h80;
    frame_chk("b01", 16'(11'b01000000011), 11, 1'b0, -1);
    b_par.load_valid = 1'b0;
    frame_chk("b80", 16'(11'b00000000111), 11, 1'b0, -1);

    // 4: valid pulse with 8'h3C during DATA is ignored
    b_par.load_valid = 1'b1;
    b_par.load_data  = 8'hA5;
    step();
    b_par.load_valid = 1'b0;
    frame_chk("ign", 16'(11'b01010010101), 11, 1'b0, 3);
    chk("ign_idle_busy", 32'(b_par.busy), 32'd0);

    // 5: reset during DATA bit 3 aborts the frame
    b_par.load_valid = 1'b1;
    b_par.load_data  = 8'h0F;
    step();
    b_par.load_valid = 1'b0;
    repeat (4) step();               // START, bit0..bit2 -> now in bit 3
    chk("abt_sframe_pre", 32'(b_par.sframe), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abt_sdata",  32'(b_par.sdata),  32'd1);
    chk("abt_busy",   32'(b_par.busy),   32'd0);
    chk("abt_sframe", 32'(b_par.sframe), 32'd0);
    chk("abt_done",   32'(b_par.done),   32'd0);
    step();
    chk("abt_done2",  32'(b_par.done),   32'd0);
    chk("abt_ready",  32'(b_par.load_ready), 32'd1);
    b_par.load_valid = 1'b1;
    b_par.load_data  = 8'h0F;
    step();
    b_par.load_valid = 1'b0;
    frame_chk("f0f", 16'(11'b01111000001), 11, 1'b0, -1);

    // 6: no-parity instance, 8'hC3 -> 10-cycle frame
    b_np.load_valid = 1'b1;
    b_np.load_data  = 8'hC3;
    step();
    b_np.load_valid = 1'b0;
    frame_chk("np_c3", 16'(10'b0110000111), 10, 1'b1, -1);
    chk("np_idle_busy",  32'(b_np.busy),  32'd0);
    chk("np_idle_sdata", 32'(b_np.sdata), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
